// File: rtl/arrseq_pkg.sv
// Shared constants for the array read sequencer: FSM state encoding and default data width.
package arrseq_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'd0,
    ST_FILL   = 8'd1,
    ST_STREAM = 8'd2
  } state_t;

endpackage

// File: rtl/array_regfile.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port,
// asynchronous active-low clear.
module array_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: cleared on reset, written one entry per cycle when we is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/array_read_sequencer.sv
// Fills a small array with base + i*step, then streams entries from a start index with
// wrap-around over a valid/ready handshake.
module array_read_sequencer
  import arrseq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] step,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [31:0]       len,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t            state, next_state;
  logic [IDX_W-1:0]  cnt, next_cnt;
  logic [DATA_W-1:0] acc, next_acc;
  logic [DATA_W-1:0] step_l, next_step;
  logic [IDX_W-1:0]  first_l, next_first;
  logic [31:0]       len_l, next_len;
  logic [31:0]       remaining, next_rem;
  logic [DATA_W-1:0] next_data;
  logic [IDX_W-1:0]  next_idx;
  logic              next_valid, next_busy, next_done;
  logic              we;
  logic [IDX_W-1:0]  inc_idx, raddr;
  logic [DATA_W-1:0] rdata;

  array_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (cnt),
    .wdata (acc),
    .raddr (raddr),
    .rdata (rdata)
  );

  // The read port serves either the stream-entry index or the successor of the current beat
  assign inc_idx = (out_idx == LAST_IDX) ? {IDX_W{1'b0}} : out_idx + IDX_ONE;
  assign raddr   = (state == ST_STREAM && !out_valid) ? first_l : inc_idx;

  // Next-state and next-output logic for the fill/stream sequencer
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_acc   = acc;
    next_step  = step_l;
    next_first = first_l;
    next_len   = len_l;
    next_rem   = remaining;
    next_data  = out_data;
    next_idx   = out_idx;
    next_valid = out_valid;
    next_busy  = busy;
    next_done  = 1'b0;
    we         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FILL;
          next_busy  = 1'b1;
          next_cnt   = {IDX_W{1'b0}};
          next_acc   = base;
          next_step  = step;
          next_first = first_idx;
          next_len   = len;
        end else begin
          next_busy  = 1'b0;
        end
      end
      ST_FILL: begin
        we       = 1'b1;
        next_acc = acc + step_l;
        if (cnt == LAST_IDX) begin
          next_state = ST_STREAM;
          // An empty run spends its final cycle only to raise done, so busy drops here
          next_busy  = (len_l != 32'd0);
        end else begin
          next_cnt   = cnt + IDX_ONE;
        end
      end
      ST_STREAM: begin
        if (!out_valid) begin
          if (len_l == 32'd0) begin
            next_done  = 1'b1;
            next_busy  = 1'b0;
            next_state = ST_IDLE;
          end else begin
            next_valid = 1'b1;
            next_data  = rdata;
            next_idx   = first_l;
            next_rem   = len_l;
          end
        end else if (out_ready) begin
          if (remaining == 32'd1) begin
            next_valid = 1'b0;
            next_done  = 1'b1;
            next_busy  = 1'b0;
            next_state = ST_IDLE;
          end else begin
            next_data  = rdata;
            next_idx   = inc_idx;
            next_rem   = remaining - 32'd1;
          end
        end else begin
          next_valid = out_valid;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_valid = 1'b0;
        next_busy  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= {IDX_W{1'b0}};
      acc       <= {DATA_W{1'b0}};
      step_l    <= {DATA_W{1'b0}};
      first_l   <= {IDX_W{1'b0}};
      len_l     <= 32'd0;
      remaining <= 32'd0;
      out_data  <= {DATA_W{1'b0}};
      out_idx   <= {IDX_W{1'b0}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      acc       <= next_acc;
      step_l    <= next_step;
      first_l   <= next_first;
      len_l     <= next_len;
      remaining <= next_rem;
      out_data  <= next_data;
      out_idx   <= next_idx;
      out_valid <= next_valid;
      busy      <= next_busy;
      done      <= next_done;
    end
  end

endmodule

// File: doc/array_read_sequencer.md
Name: array_read_sequencer

Overview:
Upstream feeder for the array-indexing FSM stages.
- Fills a small register array with an arithmetic sequence: arr[i] = base + i*step.
- Streams array entries from a programmable start index with wrap-around, over a valid/ready handshake.
- Replaces hard-coded initial-state array writes and testbench-driven index stimulus with a controlled, back-pressurable source.

Parameters:
DATA_W, 32, width of array entries and of base/step/out_data
DEPTH, 4, number of array entries; must be a power of two, >= 2
IDX_W, $clog2(DEPTH), index width (derived; do not override)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a fill+stream run; sampled only in IDLE
base  in  DATA_W  value written to arr[0]; sampled with start
step  in  DATA_W  increment between consecutive entries; sampled with start
first_idx  in  IDX_W  first index streamed; sampled with start
len  in  32  number of entries to stream; sampled with start; 0 allowed
out_data  out  DATA_W  arr[out_idx], registered
out_idx  out  IDX_W  index of the current out_data
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  consumer accepts when out_valid && out_ready at posedge
busy  out  1  high in FILL and STREAM
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (reset==0, async):
  - State goes to IDLE.
  - out_data, out_idx, out_valid, busy, done all 0.
  - Array entries cleared to 0.
  - Takes effect immediately, including mid-FILL or mid-STREAM; an in-flight beat is dropped.
- States: IDLE, FILL, STREAM. State is an 8-bit register using package constants.
- IDLE:
  - On the posedge with start==1: latch base, step, first_idx, len.
  - Set fill counter to 0 and accumulator to base; go to FILL.
  - start outside IDLE is ignored.
- FILL:
  - One write per cycle: arr[cnt] <= acc; acc <= acc + step; modulo 2^DATA_W, no saturation.
  - After the write of arr[DEPTH-1], go to STREAM, or straight to done if len==0.
  - FILL lasts exactly DEPTH cycles.
- STREAM entry:
  - On the first STREAM edge: out_valid<=1, out_data<=arr[first_idx], out_idx<=first_idx, remaining<=len.
  - With start sampled at edge E0, the first valid beat is visible after edge E(DEPTH+1).
- STREAM handshake:
  - On out_valid && out_ready: idx <= (idx==DEPTH-1) ? 0 : idx+1; remaining decrements.
  - If remaining was 1: out_valid<=0, done<=1, go to IDLE.
  - Otherwise load the next entry on the same edge. Full throughput: one beat per cycle while out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_valid hold stable.
- len==0: no beats are issued; done pulses on the edge after the last FILL write.
- done:
  - High for exactly one cycle; busy is low in that cycle.
  - start may be accepted in the done cycle, since state is already IDLE.
- Array is read-only during STREAM; only FILL writes it.

Decomposition:
- Package arrseq_pkg: state constants (ST_IDLE=0, ST_FILL=1, ST_STREAM=2) and default DATA_W.
- Sub-module array_regfile:
  - DEPTH x DATA_W storage.
  - One synchronous write port and one combinational read port.
  - Async active-low clear.
  - Sequencer FSM, counters and output registers stay in array_read_sequencer.

Test Plan:
1. base=1, step=2, first_idx=1, len=6, out_ready=1.
   - Array = 1,3,5,7.
   - Beats 3,5,7,1,3,5 with idx 1,2,3,0,1,2 on consecutive cycles.
   - First beat 5 edges after start; done one cycle after the last beat.
2. Same setup, out_ready toggled 1,0,0,1,...
   - Each beat held unchanged while ready==0.
   - No beat lost or duplicated; the total count is still 6.
3. base=32'hFFFFFFFF, step=1, first_idx=0, len=4.
   - Beats FFFFFFFF, 00000000, 00000001, 00000002 (wrap-around arithmetic).
4. len=0.
   - out_valid never rises; done pulses exactly DEPTH+1 edges after start; busy is high for DEPTH cycles.
5. Drive reset=0 during the 3rd beat of scenario 1.
   - All outputs 0 immediately, state IDLE.
   - A new start with base=10, step=10 yields 10,20,30,40 from idx 0.
6. Pulse start during FILL and STREAM with different base.
   - The pulses are ignored; the output sequence matches the original run.
